dtt_arbiter: RTL

Round-robin arbiter and sequencer that shares one `dtt` spike-timing encoder between `NUM_REQ` requesters in the BSNN input stage. It captures the granted requester's value and drives it into the encoder, then issues a single-cycle `start`. It measures the cycles until the encoder's `spike` (or a timeout) and returns that spike time to the requester with a one-hot completion pulse.

---
 rtl/dtt_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dtt_arbiter.sv
// dtt_arbiter: round-robin arbiter/sequencer sharing one dtt spike-timing
// encoder between NUM_REQ requesters.
//
// The winning requester's value is captured and driven to the encoder. A
// single-cycle start strobe is then issued, and the cycles until the encoder
// spikes (or a timeout) are counted. The count goes back to the owner with a
// one-hot done pulse.
//
// Ports:
//   CLK              clock, rising edge
//   RES              asynchronous active-high reset
//   req              per-requester request level
//   req_data         requester i value at [i*DTT_WIDTH +: DTT_WIDTH]
//   grant            one-hot encoder owner, zero when idle
//   done             one-hot single-cycle completion pulse
//   spike_time       WAIT-cycle count at spike (TIMEOUT on timeout)
//   timeout          set with done when no spike arrived
//   busy             high whenever not idle
//   dtt_input_vector captured value driven into the encoder
//   dtt_start        single-cycle encoder start strobe
//   dtt_spike        encoder spike input
module dtt_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DTT_WIDTH = 5,
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                         CLK,
  input  logic                         RES,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DTT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [CNT_W-1:0]             spike_time,
  output logic                         timeout,
  output logic                         busy,
  output logic [DTT_WIDTH-1:0]         dtt_input_vector,
  output logic                         dtt_start,
  input  logic                         dtt_spike
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]   grant_d, done_d;
  logic [CNT_W-1:0]     spike_time_d;
  logic                 timeout_d, busy_d, dtt_start_d;
  logic [DTT_WIDTH-1:0] vec_d;

  logic                 hi_found, lo_found;
  logic [IDX_W-1:0]     hi_idx, lo_idx, sel_idx;
  logic [DTT_WIDTH-1:0] sel_data;

  // Round-robin pick: lowest requester at or above the pointer, else wrap to
  // the lowest requester overall. Descending scan leaves the lowest match.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
        if (IDX_W'(j) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  // Data mux for the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_idx == IDX_W'(i)) sel_data = req_data[i*DTT_WIDTH +: DTT_WIDTH];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    wait_cnt_d   = wait_cnt_q;
    grant_d      = grant;
    done_d       = '0;
    spike_time_d = spike_time;
    timeout_d    = timeout;
    vec_d        = dtt_input_vector;
    dtt_start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lo_found) begin
          grant_d     = NUM_REQ'(1) << sel_idx;
          grant_idx_d = sel_idx;
          vec_d       = sel_data;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // Strobe is registered, so it is high during START.
        dtt_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (dtt_spike) begin
          spike_time_d = wait_cnt_q;
          timeout_d    = 1'b0;
          done_d       = grant;
          state_d      = S_DONE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          spike_time_d = CNT_W'(TIMEOUT);
          timeout_d    = 1'b1;
          done_d       = grant;
          state_d      = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
        grant_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q          <= S_IDLE;
      rr_ptr_q         <= '0;
      grant_idx_q      <= '0;
      wait_cnt_q       <= '0;
      grant            <= '0;
      done             <= '0;
      spike_time       <= '0;
      timeout          <= 1'b0;
      busy             <= 1'b0;
      dtt_input_vector <= '0;
      dtt_start        <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_idx_q      <= grant_idx_d;
      wait_cnt_q       <= wait_cnt_d;
      grant            <= grant_d;
      done             <= done_d;
      spike_time       <= spike_time_d;
      timeout          <= timeout_d;
      busy             <= busy_d;
      dtt_input_vector <= vec_d;
      dtt_start        <= dtt_start_d;
    end
  end

endmodule
